// File: rtl/sq_out_normalizer_pkg.sv
// sq_out_normalizer_pkg: shared defaults, carry-width helper and FSM state type
package sq_out_normalizer_pkg;
    localparam int MOD_LEN_DEF            = 1024;
    localparam int WORD_LEN_DEF           = 16;
    localparam int BIT_LEN_DEF            = 17;
    localparam int REDUNDANT_ELEMENTS_DEF = 2;

    function automatic int carry_width(input int bit_len, input int word_len);
        return bit_len - word_len + 1;
    endfunction

    localparam int CARRY_LEN_DEF = carry_width(BIT_LEN_DEF, WORD_LEN_DEF);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sq_out_normalizer_if.sv
// sq_out_normalizer_if: squarer-side input and consumer-side result handshake
interface sq_out_normalizer_if
    import sq_out_normalizer_pkg::*;
#(
    parameter int WORD_LEN     = WORD_LEN_DEF,
    parameter int NUM_ELEMENTS = MOD_LEN_DEF / WORD_LEN_DEF + REDUNDANT_ELEMENTS_DEF
);
    logic [NUM_ELEMENTS*2*WORD_LEN-1:0] in_data;
    logic                               in_valid;
    logic                               in_ready;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]   out_data;
    logic                               out_overflow;
    logic                               out_fmt_err;
    logic                               out_valid;
    logic                               out_ready;
    logic                               drop;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_overflow, out_fmt_err, out_valid, drop
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_overflow, out_fmt_err, out_valid, drop
    );
endinterface

// File: rtl/sq_carry_slice.sv
// sq_carry_slice: combinational carry ripple over ELEMS redundant coefficients
module sq_carry_slice
    import sq_out_normalizer_pkg::*;
#(
    parameter int ELEMS     = 6,
    parameter int WORD_LEN  = WORD_LEN_DEF,
    parameter int BIT_LEN   = BIT_LEN_DEF,
    parameter int CARRY_LEN = carry_width(BIT_LEN, WORD_LEN)
) (
    input  logic [CARRY_LEN-1:0]      carry_in,
    input  logic [ELEMS*BIT_LEN-1:0]  coeffs,
    output logic [ELEMS*WORD_LEN-1:0] digits,
    output logic [CARRY_LEN-1:0]      carry_out
);
    logic [BIT_LEN:0] sum;

    always_comb begin
        sum       = '0;
        digits    = '0;
        carry_out = carry_in;
        for (int i = 0; i < ELEMS; i++) begin
            sum = {1'b0, coeffs[i*BIT_LEN +: BIT_LEN]} + (BIT_LEN+1)'(carry_out);
            digits[i*WORD_LEN +: WORD_LEN] = sum[WORD_LEN-1:0];
            carry_out = sum[BIT_LEN:WORD_LEN];
        end
    end
endmodule

// File: rtl/sq_out_normalizer.sv
// sq_out_normalizer: folds a redundant square result into canonical binary,
// ELEMS_PER_CYCLE coefficients per cycle with a fixed STEPS-cycle latency.
module sq_out_normalizer
    import sq_out_normalizer_pkg::*;
#(
    parameter int MOD_LEN            = MOD_LEN_DEF,
    parameter int WORD_LEN           = WORD_LEN_DEF,
    parameter int REDUNDANT_ELEMENTS = REDUNDANT_ELEMENTS_DEF,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int BIT_LEN            = BIT_LEN_DEF,
    parameter int ELEMS_PER_CYCLE    = 6
) (
    input logic               clk,
    input logic               reset,
    sq_out_normalizer_if.slave bus
);
    localparam int STEPS     = NUM_ELEMENTS / ELEMS_PER_CYCLE;
    localparam int STEP_W    = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam int FIELD_LEN = 2 * WORD_LEN;
    localparam int CARRY_LEN = carry_width(BIT_LEN, WORD_LEN);
    localparam int OUT_W     = NUM_ELEMENTS * WORD_LEN;
    localparam int SLICE_IN  = ELEMS_PER_CYCLE * BIT_LEN;
    localparam int SLICE_OUT = ELEMS_PER_CYCLE * WORD_LEN;

    if (NUM_ELEMENTS % ELEMS_PER_CYCLE != 0) begin : g_bad_fold
        $error("NUM_ELEMENTS must be a multiple of ELEMS_PER_CYCLE");
    end

    state_t                          state, state_nxt;
    logic [STEP_W-1:0]               step;
    logic [CARRY_LEN-1:0]            carry, carry_out;
    logic [NUM_ELEMENTS*BIT_LEN-1:0] coeff, coeff_in;
    logic [OUT_W-1:0]                out_q;
    logic [SLICE_OUT-1:0]            digits;
    logic                            fmt_in, fmt_q, drop_q, last;

    always_comb begin
        coeff_in = '0;
        fmt_in   = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            coeff_in[j*BIT_LEN +: BIT_LEN] = bus.in_data[j*FIELD_LEN +: BIT_LEN];
            fmt_in = fmt_in | (|bus.in_data[j*FIELD_LEN+BIT_LEN +: FIELD_LEN-BIT_LEN]);
        end
    end

    // coeff is shifted down each RUN cycle, so the slice always sees the current group in its low bits
    sq_carry_slice #(
        .ELEMS    (ELEMS_PER_CYCLE),
        .WORD_LEN (WORD_LEN),
        .BIT_LEN  (BIT_LEN),
        .CARRY_LEN(CARRY_LEN)
    ) u_slice (
        .carry_in (carry),
        .coeffs   (coeff[SLICE_IN-1:0]),
        .digits   (digits),
        .carry_out(carry_out)
    );

    assign last = step == STEP_W'(STEPS - 1);

    always_comb begin
        state_nxt = state == IDLE ? (bus.in_valid ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step   <= '0;
            carry  <= '0;
            coeff  <= '0;
            out_q  <= '0;
            fmt_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= bus.in_valid && state != IDLE;
            if (state == IDLE && bus.in_valid) begin
                coeff <= coeff_in;
                fmt_q <= fmt_in;
                carry <= '0;
                step  <= '0;
            end else if (state == RUN) begin
                coeff <= coeff >> SLICE_IN;
                out_q <= OUT_W'({digits, out_q} >> SLICE_OUT);
                carry <= carry_out;
                step  <= step + 1'b1;
            end
        end
    end

    assign bus.in_ready     = state == IDLE;
    assign bus.out_valid    = state == DONE;
    assign bus.out_data     = out_q;
    assign bus.out_overflow = |carry;
    assign bus.out_fmt_err  = fmt_q;
    assign bus.drop         = drop_q;
endmodule

// File: tb/tb_sq_out_normalizer.sv
// tb_sq_out_normalizer: directed scoreboard bench, expectations from a big-integer sum model
module tb_sq_out_normalizer;
    localparam int NE    = 66;
    localparam int WL    = 16;
    localparam int BL    = 17;
    localparam int EPC   = 6;
    localparam int STEPS = NE / EPC;
    localparam int FL    = 2 * WL;
    localparam int NW    = NE * WL;
    localparam int IW    = NE * FL;

    typedef struct {
        logic [NW-1:0] d;
        logic          o;
        logic          f;
    } exp_t;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    int      npass = 0;
    int      ntot = 0;
    exp_t    sb[$];
    logic [IW-1:0] v;

    always #5 clk = ~clk;

    sq_out_normalizer_if #(.WORD_LEN(WL), .NUM_ELEMENTS(NE)) bus ();

    sq_out_normalizer #(
        .MOD_LEN(1024), .WORD_LEN(WL), .REDUNDANT_ELEMENTS(2),
        .NUM_ELEMENTS(NE), .BIT_LEN(BL), .ELEMS_PER_CYCLE(EPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [IW-1:0] x);
        logic [NW+3:0] acc;
        exp_t e;
        acc = '0;
        e.f = 1'b0;
        for (int j = 0; j < NE; j++) begin
            acc = acc + ((NW+4)'(x[j*FL +: BL]) << (WL * j));
            e.f = e.f | (|x[j*FL+BL +: FL-BL]);
        end
        e.d = acc[NW-1:0];
        e.o = |acc[NW+3:NW];
        return e;
    endfunction

    task automatic accept(input logic [IW-1:0] x);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", bus.in_ready, 1);
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        sb.push_back(model(x));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, STEPS);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_sb"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, bus.out_valid, 1);
            chk({tag, "_data"}, bus.out_data, e.d);
            chk({tag, "_ovf"}, bus.out_overflow, e.o);
            chk({tag, "_fmt"}, bus.out_fmt_err, e.f);
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_low"}, bus.out_valid, 0);
        chk({tag, "_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic run_txn(input string tag, input logic [IW-1:0] x);
        accept(x);
        wait_out(tag);
        check_out(tag);
        release_out(tag);
    endtask

    task automatic rand_vec(input bit hi_bits);
        v = '0;
        for (int j = 0; j < NE; j++) begin
            v[j*FL +: BL] = BL'($urandom);
            if (hi_bits && $urandom_range(0, 15) == 0) v[j*FL+BL +: FL-BL] = (FL-BL)'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops, stray;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ovf", bus.out_overflow, 0);
        chk("rst_fmt", bus.out_fmt_err, 0);
        chk("rst_drop", bus.drop, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("rst_ready", bus.in_ready, 1);

        v = '0;
        run_txn("zero", v);

        v = '0;
        v[0 +: BL] = 17'h1FFFF;
        run_txn("c0_max", v);

        v = '0;
        v[0 +: BL] = 17'h10000;
        for (int j = 1; j < NE; j++) v[j*FL +: BL] = 17'h0FFFF;
        run_txn("ripple", v);

        v = '0;
        v[3*FL+BL +: FL-BL] = 15'h0001;
        run_txn("fmt_err", v);

        for (int t = 0; t < 3; t++) begin
            rand_vec(t == 2);
            run_txn($sformatf("rand%0d", t), v);
        end

        // backpressure: hold DONE, pulse in_valid once, then hand over with a new input waiting
        rand_vec(1'b0);
        accept(v);
        wait_out("bp");
        drops = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 1);
            tick();
            drops += int'(bus.drop);
            chk($sformatf("bp_hold_valid%0d", c), bus.out_valid, 1);
            chk($sformatf("bp_hold_ready%0d", c), bus.in_ready, 0);
            chk($sformatf("bp_hold_data%0d", c), bus.out_data, sb[0].d);
        end
        chk("bp_drop_count", drops, 1);
        check_out("bp");
        rand_vec(1'b0);
        bus.in_data   = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("same_cycle_not_ready", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        chk("same_cycle_idle", bus.in_ready, 1);
        chk("same_cycle_valid_low", bus.out_valid, 0);
        sb.push_back(model(v));
        tick();
        bus.in_valid = 1'b0;
        wait_out("next");
        check_out("next");
        release_out("next");

        // abandon a transaction mid-RUN
        rand_vec(1'b1);
        accept(v);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_ovf", bus.out_overflow, 0);
        chk("mid_rst_fmt", bus.out_fmt_err, 0);
        chk("mid_rst_drop", bus.drop, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            stray += int'(bus.out_valid);
        end
        chk("mid_rst_no_stray", stray, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        v = '0;
        v[0 +: BL] = 17'h1FFFF;
        v[65*FL +: BL] = 17'h1FFFF;
        run_txn("post_rst", v);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
